// File: rtl/glacier_pkg.sv
// Shared constants, FSM state type and LFSR helper for the glacier obstacle scheduler.
package glacier_pkg;

    localparam int SCREEN_H    = 720;
    localparam int SPRITE_SIZE = 128;

    localparam logic [15:0] DEF_SPAWN_X = 16'd276;
    localparam logic [15:0] DEF_SPAWN_Y = 16'd96;
    localparam logic [15:0] DEF_Y_LIMIT = 16'(SCREEN_H - SPRITE_SIZE);

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_WAIT,
        S_UPDATE,
        S_SPAWN,
        S_DONE
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronises raw v_sync into the clock domain and emits a registered
// one-cycle tick on each rising edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic v_sync,
    output logic tick
);

    logic sync1, sync2, sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= v_sync;
            sync2 <= sync1;
            sync3 <= sync2;
            tick  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/glacier_spawn_ctrl.sv
// Per-frame glacier slot scheduler: walks slots one per cycle through a shared
// move/retire datapath, then spawns into the lowest free slot on an LFSR-jittered gap.
//
//  state    | meaning
//  S_WAIT   | idle, waiting for a frame tick (or a pending one)
//  S_UPDATE | advance/retire slot idx, one slot per cycle
//  S_SPAWN  | timer countdown / spawn, LFSR step
//  S_DONE   | o_frame_done pulse, outputs stable
module glacier_spawn_ctrl
    import glacier_pkg::*;
#(
    parameter int          N_SLOTS       = 4,
    parameter logic [15:0] SPAWN_X       = DEF_SPAWN_X,
    parameter logic [15:0] SPAWN_Y       = DEF_SPAWN_Y,
    parameter logic [15:0] Y_LIMIT       = DEF_Y_LIMIT,
    parameter logic [15:0] STEP          = 16'd1,
    parameter logic [15:0] SPAWN_GAP_MIN = 16'd32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_v_sync,
    input  logic                   i_is_finished,
    input  logic                   i_is_dead,
    input  logic                   i_restart,
    output logic [16*N_SLOTS-1:0]  o_slot_x,
    output logic [16*N_SLOTS-1:0]  o_slot_y,
    output logic [N_SLOTS-1:0]     o_active,
    output logic                   o_frame_done,
    output logic                   o_busy,
    output logic                   o_overrun
);

    localparam int               IDX_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        slot_x [N_SLOTS];
    logic [15:0]        slot_y [N_SLOTS];
    logic [N_SLOTS-1:0] active;
    logic [15:0]        timer;
    logic [15:0]        lfsr;
    logic               pending;
    logic               tick;
    logic               frozen;
    logic [15:0]        cur_x, cur_y;
    logic               retire;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;

    frame_tick_gen u_tick (
        .clk    (i_clk),
        .rst    (i_reset),
        .v_sync (i_v_sync),
        .tick   (tick)
    );

    assign frozen = i_is_finished | i_is_dead;
    assign cur_x  = slot_x[idx];
    assign cur_y  = slot_y[idx];
    // Retire test comes before the subtract so x can never wrap below zero.
    assign retire = (cur_x < STEP) || (cur_y >= Y_LIMIT);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (!active[k]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_WAIT;
            idx          <= '0;
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_x[k] <= '0;
                slot_y[k] <= '0;
            end
            active       <= '0;
            timer        <= '0;
            lfsr         <= LFSR_SEED;
            pending      <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (i_restart) begin
            state        <= S_WAIT;
            idx          <= '0;
            active       <= '0;
            timer        <= '0;
            pending      <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (tick && state != S_WAIT) begin
                if (pending)
                    o_overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end
            case (state)
                S_WAIT: begin
                    if (tick || pending) begin
                        state   <= S_UPDATE;
                        idx     <= '0;
                        o_busy  <= 1'b1;
                        // a fresh tick arriving while draining the pending one stays queued
                        pending <= tick && pending;
                    end
                end
                S_UPDATE: begin
                    if (!frozen && active[idx]) begin
                        if (retire) begin
                            active[idx] <= 1'b0;
                        end else begin
                            slot_x[idx] <= cur_x - STEP;
                            slot_y[idx] <= cur_y + STEP;
                        end
                    end
                    if (idx == LAST_IDX)
                        state <= S_SPAWN;
                    else
                        idx <= idx + 1'b1;
                end
                S_SPAWN: begin
                    if (!frozen) begin
                        lfsr <= lfsr_next(lfsr);
                        if (timer != 16'd0) begin
                            timer <= timer - 16'd1;
                        end else if (free_found) begin
                            slot_x[free_idx] <= SPAWN_X;
                            slot_y[free_idx] <= SPAWN_Y;
                            active[free_idx] <= 1'b1;
                            timer            <= SPAWN_GAP_MIN + {11'd0, lfsr[4:0]};
                        end
                    end
                    state        <= S_DONE;
                    o_busy       <= 1'b0;
                    o_frame_done <= 1'b1;
                end
                S_DONE:  state <= S_WAIT;
                default: state <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < N_SLOTS; k++) begin
            o_slot_x[16*k +: 16] = slot_x[k];
            o_slot_y[16*k +: 16] = slot_y[k];
        end
    end

    assign o_active = active;

endmodule

// File: tb/tb_glacier_spawn_ctrl.sv
// Bench for glacier_spawn_ctrl: four parameter variants driven by one v_sync,
// checked every frame against a slot-level reference model plus literal pins.
module tb_glacier_spawn_ctrl;

    localparam int          ND = 4;
    localparam logic [15:0] P_SPX  [ND] = '{16'd276, 16'd1000, 16'd276, 16'd276};
    localparam logic [15:0] P_GAP  [ND] = '{16'd32,  16'd1000, 16'd0,   16'd1000};
    localparam logic [15:0] P_SEED [ND] = '{16'hACE1, 16'hACE1, 16'h0000, 16'hACE1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        fin     [ND];
    logic        dead    [ND];
    logic        restart [ND];
    logic [63:0] sx  [ND];
    logic [63:0] sy  [ND];
    logic [3:0]  act [ND];
    logic        fd   [ND];
    logic        busy [ND];
    logic        ovr  [ND];

    int n_tests = 0;
    int n_fail  = 0;

    int          mx [ND][4];
    int          my [ND][4];
    bit          ma [ND][4];
    int          mt [ND];
    logic [15:0] ml [ND];
    int          frames [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        glacier_spawn_ctrl #(
            .N_SLOTS       (4),
            .SPAWN_X       (P_SPX[g]),
            .SPAWN_GAP_MIN (P_GAP[g]),
            .LFSR_SEED     (P_SEED[g])
        ) u_dut (
            .i_clk         (clk),
            .i_reset       (rst),
            .i_v_sync      (vsync),
            .i_is_finished (fin[g]),
            .i_is_dead     (dead[g]),
            .i_restart     (restart[g]),
            .o_slot_x      (sx[g]),
            .o_slot_y      (sy[g]),
            .o_active      (act[g]),
            .o_frame_done  (fd[g]),
            .o_busy        (busy[g]),
            .o_overrun     (ovr[g])
        );
    end

    task automatic check(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic void model_reset(input int d);
        for (int k = 0; k < 4; k++) begin
            mx[d][k] = 0;
            my[d][k] = 0;
            ma[d][k] = 1'b0;
        end
        mt[d] = 0;
        ml[d] = P_SEED[d];
        frames[d] = 0;
    endfunction

    // One game frame: move or retire every live glacier, then count down or spawn.
    function automatic void model_frame(input int d, input bit frz);
        int fi;
        if (frz) return;
        for (int k = 0; k < 4; k++) begin
            if (ma[d][k]) begin
                if (mx[d][k] < 1 || my[d][k] >= 592) begin
                    ma[d][k] = 1'b0;
                end else begin
                    mx[d][k] = mx[d][k] - 1;
                    my[d][k] = my[d][k] + 1;
                end
            end
        end
        if (mt[d] != 0) begin
            mt[d] = mt[d] - 1;
        end else begin
            fi = -1;
            for (int k = 3; k >= 0; k--)
                if (!ma[d][k]) fi = k;
            if (fi >= 0) begin
                mx[d][fi] = int'(P_SPX[d]);
                my[d][fi] = 96;
                ma[d][fi] = 1'b1;
                mt[d] = int'(P_GAP[d]) + int'(ml[d] % 16'd32);
            end
        end
        ml[d] = {ml[d][14:0], ml[d][15] ^ ml[d][13] ^ ml[d][12] ^ ml[d][10]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                if (fd[d]) begin
                    logic [3:0] ea;
                    bit ok;
                    model_frame(d, dead[d]);
                    frames[d]++;
                    ok = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        ea[k] = ma[d][k];
                        if (ma[d][k] && (sx[d][16*k +: 16] != 16'(mx[d][k]) ||
                                         sy[d][16*k +: 16] != 16'(my[d][k])))
                            ok = 1'b0;
                    end
                    n_tests++;
                    if (!ok || act[d] !== ea) begin
                        n_fail++;
                        $display("FAIL model dut%0d frame %0d: active %b x %h y %h expected active %b x0 %0d y0 %0d",
                                 d, frames[d], act[d], sx[d], sy[d], ea, mx[d][0], my[d][0]);
                    end
                end
            end
        end
    end

    int fd_seen = 0;

    task automatic frame(input bit chk_lat);
        int cnt = 0;
        @(negedge clk);
        vsync = 1'b1;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!fd[0] && cnt < 40);
        if (fd[0]) fd_seen++;
        if (cnt >= 40) check("frame_done_timeout", 0, 1);
        if (chk_lat) check("latency", cnt, 9);
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames_to(input int n);
        while (frames[0] + (dead[0] ? 0 : 0) < n && fd_seen < 2000) frame(1'b0);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            fin[d] = 1'b0;
            dead[d] = 1'b0;
            restart[d] = 1'b0;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_active%0d", d), act[d], 0);
            check($sformatf("reset_xy%0d", d), sx[d] | sy[d], 0);
            check($sformatf("reset_flags%0d", d), {fd[d], busy[d], ovr[d]}, 0);
        end

        frame(1'b1);
        check("f1_active", act[0], 4'b0001);
        check("f1_slot0_x", sx[0][15:0], 276);
        check("f1_slot0_y", sy[0][15:0], 96);
        check("f1_overrun", ovr[0], 0);
        check("f1_busy", busy[0], 0);

        frames_to(4);
        check("fill_4_frames", act[2], 4'b1111);
        frames_to(5);
        check("fill_5th_no_spawn", act[2], 4'b1111);
        check("fill_slot3_xy", {sx[2][63:48], sy[2][63:48]}, {16'd275, 16'd97});

        frames_to(10);
        check("f10_slot0_xy", {sx[0][15:0], sy[0][15:0]}, {16'd267, 16'd105});
        frames_to(34);
        check("f34_slot1_idle", act[0][1], 0);
        frames_to(35);
        check("f35_active", act[0], 4'b0011);
        check("f35_slot1_xy", {sx[0][31:16], sy[0][31:16]}, {16'd276, 16'd96});
        check("f35_slot0_xy", {sx[0][15:0], sy[0][15:0]}, {16'd242, 16'd130});

        dead[0] = 1'b1;
        fd_seen = 0;
        for (int i = 0; i < 5; i++) frame(1'b0);
        check("dead_pulses", fd_seen, 5);
        check("dead_slot0_hold", {sx[0][15:0], sy[0][15:0]}, {16'd242, 16'd130});
        check("dead_slot1_hold", {sx[0][31:16], sy[0][31:16]}, {16'd276, 16'd96});
        dead[0] = 1'b0;
        frame(1'b1);
        check("resume_slot0_xy", {sx[0][15:0], sy[0][15:0]}, {16'd241, 16'd131});

        frames_to(277);
        check("xwall_active", act[3], 4'b0001);
        check("xwall_slot0_xy", {sx[3][15:0], sy[3][15:0]}, {16'd0, 16'd372});
        frames_to(278);
        check("xwall_retired", act[3], 0);
        check("xwall_x_held", sx[3][15:0], 0);

        frames_to(497);
        check("ylim_active", act[1], 4'b0001);
        check("ylim_slot0_xy", {sx[1][15:0], sy[1][15:0]}, {16'd504, 16'd592});
        frames_to(498);
        check("ylim_retired", act[1], 0);
        check("ylim_xy_held", {sx[1][15:0], sy[1][15:0]}, {16'd504, 16'd592});

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            @(negedge clk);
        end
        repeat (80) @(negedge clk);
        for (int d = 0; d < ND; d++)
            check($sformatf("overrun%0d", d), ovr[d], 1);

        begin
            int cnt = 0;
            vsync = 1'b1;
            while (!busy[2] && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 40) check("busy_timeout", 0, 1);
            @(negedge clk);
            restart[2] = 1'b1;
            for (int k = 0; k < 4; k++) ma[2][k] = 1'b0;
            mt[2] = 0;
            @(negedge clk);
            restart[2] = 1'b0;
            check("restart_active", act[2], 0);
            check("restart_overrun", ovr[2], 0);
            check("restart_busy", busy[2], 0);
            check("sticky_overrun", ovr[0], 1);
            vsync = 1'b0;
            repeat (30) @(negedge clk);
        end
        frame(1'b1);
        check("post_restart_active", act[2], 4'b0001);
        check("post_restart_xy", {sx[2][15:0], sy[2][15:0]}, {16'd276, 16'd96});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

endmodule
